// File: rtl/mem_access.sv
// Memory-access stage: single-outstanding data-bus load/store engine with load formatting.
// Optional misalignment trapping is enabled by defining MISALIGN_TRAP_EN.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pc,
  input  logic [4:0]  rd,
  input  logic [63:0] result,
  input  logic [63:0] data2,
  input  logic        load_en,
  input  logic        store_en,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic        stall,
  output logic [4:0]  ma_rd,
  output logic [63:0] ma_out,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic [63:0] req_addr,
  output logic [63:0] req_wdata,
  output logic [7:0]  req_wmask,
  input  logic        resp_valid,
  input  logic [63:0] resp_rdata,
  output logic [63:0] wb_pc,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_out
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        trap_en,
  output logic [3:0]  trap_cause,
  output logic [63:0] trap_val
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, state_nx;

  logic [63:0] pc_p1;
  logic [4:0]  rd_p1;
  logic [2:0]  off_p1;
  logic [1:0]  size_p1;
  logic        uns_p1;
  logic        store_p1;
  logic [63:0] rdata_p2;

  logic        mem_op;
  logic        start;
  logic [63:0] eaddr;

  function automatic logic [2:0] low_mask(input logic [1:0] sz);
    logic [2:0] m;
    case (sz)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] fmt_load(input logic [63:0] rdata, input logic [2:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [63:0] d;
    logic [63:0] r;
    d = rdata >> {off, 3'b000};
    case (sz)
      2'd0:    r = uns ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      2'd1:    r = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      2'd2:    r = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign mem_op = load_en | store_en;

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = |(result[2:0] & low_mask(size));
  assign eaddr    = result;
  assign start    = mem_op & ~misalign;
`else
  // Without trapping, misaligned accesses silently round down to the natural boundary.
  assign eaddr = {result[63:3], result[2:0] & ~low_mask(size)};
  assign start = mem_op;
`endif

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    ma_rd    = rd;
    ma_out   = result;
`ifdef MISALIGN_TRAP_EN
    trap_en    = 1'b0;
    trap_cause = 4'd0;
    trap_val   = 64'd0;
`endif
    case (state)
      IDLE: begin
        if (mem_op) begin
          ma_rd  = 5'd0;
          ma_out = 64'd0;
`ifdef MISALIGN_TRAP_EN
          if (misalign) begin
            trap_en    = 1'b1;
            trap_cause = store_en ? 4'd6 : 4'd4;
            trap_val   = result;
          end
`endif
          if (start) begin
            stall    = 1'b1;
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        stall  = 1'b1;
        ma_rd  = 5'd0;
        ma_out = 64'd0;
        if (req_valid && req_ready) state_nx = WAIT;
      end
      WAIT: begin
        stall  = 1'b1;
        ma_rd  = 5'd0;
        ma_out = 64'd0;
        if (resp_valid) state_nx = DONE;
      end
      default: begin
        if (store_p1) begin
          ma_rd  = 5'd0;
          ma_out = 64'd0;
        end else begin
          ma_rd  = rd_p1;
          ma_out = fmt_load(rdata_p2, off_p1, size_p1, uns_p1);
        end
        state_nx = IDLE;
      end
    endcase
  end

  // Control state, bus request registers and the MA/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= 64'd0;
      req_wdata <= 64'd0;
      req_wmask <= 8'd0;
      wb_pc     <= 64'd0;
      wb_rd     <= 5'd0;
      wb_out    <= 64'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        req_valid <= 1'b1;
        req_write <= store_en;
        req_addr  <= {eaddr[63:3], 3'b000};
        req_wdata <= store_en ? (data2 << {eaddr[2:0], 3'b000}) : 64'd0;
        req_wmask <= store_en ? lane_mask(size, eaddr[2:0]) : 8'd0;
      end else if (state == REQ && req_ready) begin
        req_valid <= 1'b0;
      end
      if (!stall) begin
        wb_pc  <= (state == DONE) ? pc_p1 : pc;
        wb_rd  <= ma_rd;
        wb_out <= ma_out;
      end else begin
        wb_rd  <= 5'd0;
      end
    end
  end

  // Latched op fields (p1) and captured response data (p2)
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      pc_p1    <= pc;
      rd_p1    <= rd;
      off_p1   <= eaddr[2:0];
      size_p1  <= size;
      uns_p1   <= unsigned_ld;
      store_p1 <= store_en;
    end
    if (state == WAIT && resp_valid) rdata_p2 <= resp_rdata;
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector tables for ALU and memory ops plus
// backpressure, misalignment and mid-transaction reset sequences.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc, result, data2;
  logic [4:0]  rd;
  logic        load_en, store_en, unsigned_ld;
  logic [1:0]  size;
  logic        stall;
  logic [4:0]  ma_rd;
  logic [63:0] ma_out;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic [63:0] wb_pc, wb_out;
  logic [4:0]  wb_rd;
`ifdef MISALIGN_TRAP_EN
  logic        trap_en;
  logic [3:0]  trap_cause;
  logic [63:0] trap_val;
`endif

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .rd(rd), .result(result), .data2(data2),
    .load_en(load_en), .store_en(store_en), .size(size), .unsigned_ld(unsigned_ld),
    .stall(stall), .ma_rd(ma_rd), .ma_out(ma_out),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_out(wb_out)
`ifdef MISALIGN_TRAP_EN
    , .trap_en(trap_en), .trap_cause(trap_cause), .trap_val(trap_val)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] result;
    logic [63:0] pc;
  } alu_t;

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] d2;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_wmask;
    logic [4:0]  e_rd;
    logic [63:0] e_out;
  } mvec_t;

  alu_t  av[4];
  mvec_t mv[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] d2, input logic [4:0] r,
                        input logic [63:0] p);
    load_en = ld; store_en = st; size = sz; unsigned_ld = uns;
    result = addr; data2 = d2; rd = r; pc = p;
  endtask

  // Caller drives the op at posedge+1; runs the bus handshake and checks it end to end.
  task automatic mem_txn(input string tag, input int rdy_dly, input int rsp_dly,
                         input logic [63:0] rdata, input logic stale,
                         input logic [63:0] e_addr, input logic e_wr,
                         input logic [63:0] e_wdata, input logic [7:0] e_wmask,
                         input logic [4:0] e_rd, input logic [63:0] e_out,
                         input logic [63:0] e_pc);
    int stalls = 0, vcnt = 0, wcnt = 0, unstable = 0;
    bit acc = 0, resp_done = 0, done = 0, first = 1;
    logic [63:0] fa, fd;
    logic [7:0]  fm;
    logic        fw;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      req_ready = req_valid && (vcnt >= rdy_dly);
      if (acc && !resp_done) begin
        if (wcnt == rsp_dly) begin
          resp_valid = 1'b1; resp_rdata = rdata; resp_done = 1;
        end else begin
          resp_valid = 1'b0; wcnt++;
        end
      end else if (!acc && stale) begin
        resp_valid = 1'b1; resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end else begin
        resp_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) chk({tag, ".stall0"}, {63'd0, stall}, 64'd1);
      if (stall) stalls++;
      else if (cyc > 0) begin
        done = 1;
        chk({tag, ".ma_rd"}, {59'd0, ma_rd}, {59'd0, e_rd});
        chk({tag, ".ma_out"}, ma_out, e_out);
      end
      if (req_valid) begin
        if (first) begin
          first = 0;
          fa = req_addr; fd = req_wdata; fm = req_wmask; fw = req_write;
          chk({tag, ".req_addr"}, req_addr, e_addr);
          chk({tag, ".req_write"}, {63'd0, req_write}, {63'd0, e_wr});
          if (e_wr) begin
            chk({tag, ".req_wdata"}, req_wdata, e_wdata);
            chk({tag, ".req_wmask"}, {56'd0, req_wmask}, {56'd0, e_wmask});
          end
        end else if (fa !== req_addr || fd !== req_wdata || fm !== req_wmask || fw !== req_write) begin
          unstable++;
        end
        vcnt++;
        if (req_ready) acc = 1;
      end
      @(posedge clk); #1;
    end
    req_ready = 1'b0;
    resp_valid = 1'b0;
    chk({tag, ".done"}, {63'd0, done}, 64'd1);
    chk({tag, ".stalls"}, stalls, 3 + rdy_dly + rsp_dly);
    chk({tag, ".req_cycles"}, vcnt, rdy_dly + 1);
    chk({tag, ".unstable"}, unstable, 0);
    chk({tag, ".wb_rd"}, {59'd0, wb_rd}, {59'd0, e_rd});
    chk({tag, ".wb_out"}, wb_out, e_out);
    chk({tag, ".wb_pc"}, wb_pc, e_pc);
    set_op(0, 0, 0, 0, 64'h77, 0, 5'd7, e_pc + 4);
    @(negedge clk);
    chk({tag, ".after_stall"}, {63'd0, stall}, 64'd0);
    chk({tag, ".after_ma_rd"}, {59'd0, ma_rd}, 64'd7);
    @(posedge clk); #1;
  endtask

  initial begin
    req_ready = 0; resp_valid = 0; resp_rdata = 0;
    set_op(0, 0, 0, 0, 64'h55, 0, 5'd3, 64'h40);

    av[0] = '{5'd5,  64'h1234,                64'h1000};
    av[1] = '{5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1004};
    av[2] = '{5'd0,  64'hA5A5_0000_1234_5A5A, 64'h1008};
    av[3] = '{5'd17, 64'h0,                   64'h100C};

    //         ld st sz uns addr     data2                   rd     rdata                    e_addr   e_wdata                 e_wmask e_rd  e_out
    mv[0]  = '{1, 0, 0, 0, 64'h1003, 64'h0,                  5'd3,  64'h0000_0000_8000_0000, 64'h1000, 64'h0,                  8'h00, 5'd3, 64'hFFFF_FFFF_FFFF_FF80};
    mv[1]  = '{0, 1, 1, 0, 64'h2006, 64'hABCD,               5'd9,  64'h0,                   64'h2000, 64'hABCD_0000_0000_0000, 8'hC0, 5'd0, 64'h0};
    mv[2]  = '{1, 0, 0, 1, 64'h1003, 64'h0,                  5'd4,  64'h0000_0000_8000_0000, 64'h1000, 64'h0,                  8'h00, 5'd4, 64'h80};
    mv[3]  = '{1, 0, 1, 0, 64'h0102, 64'h0,                  5'd10, 64'h0000_0000_8001_0000, 64'h0100, 64'h0,                  8'h00, 5'd10, 64'hFFFF_FFFF_FFFF_8001};
    mv[4]  = '{1, 0, 2, 1, 64'h4004, 64'h0,                  5'd11, 64'h89AB_CDEF_0000_0000, 64'h4000, 64'h0,                  8'h00, 5'd11, 64'h0000_0000_89AB_CDEF};
    mv[5]  = '{1, 0, 2, 0, 64'h4004, 64'h0,                  5'd12, 64'h89AB_CDEF_0000_0000, 64'h4000, 64'h0,                  8'h00, 5'd12, 64'hFFFF_FFFF_89AB_CDEF};
    mv[6]  = '{1, 0, 3, 1, 64'h5000, 64'h0,                  5'd13, 64'hFEDC_BA98_7654_3210, 64'h5000, 64'h0,                  8'h00, 5'd13, 64'hFEDC_BA98_7654_3210};
    mv[7]  = '{0, 1, 3, 0, 64'h5008, 64'h1122_3344_5566_7788, 5'd14, 64'h0,                  64'h5008, 64'h1122_3344_5566_7788, 8'hFF, 5'd0, 64'h0};
    mv[8]  = '{0, 1, 0, 0, 64'h600F, 64'hFFFF_FFFF_FFFF_FF5A, 5'd15, 64'h0,                  64'h6008, 64'h5A00_0000_0000_0000, 8'h80, 5'd0, 64'h0};
    mv[9]  = '{0, 1, 2, 0, 64'h7004, 64'hDEAD_BEEF,          5'd16, 64'h0,                   64'h7000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 5'd0, 64'h0};
    mv[10] = '{1, 0, 0, 0, 64'h8000, 64'h0,                  5'd0,  64'h0000_0000_0000_007F, 64'h8000, 64'h0,                  8'h00, 5'd0, 64'h7F};

    // Reset values, with a non-memory op presented across a reset edge
    #12;
    chk("rst.req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst.req_write", {63'd0, req_write}, 64'd0);
    chk("rst.req_wmask", {56'd0, req_wmask}, 64'd0);
    chk("rst.req_addr", req_addr, 64'd0);
    chk("rst.req_wdata", req_wdata, 64'd0);
    chk("rst.wb_pc", wb_pc, 64'd0);
    chk("rst.wb_rd", {59'd0, wb_rd}, 64'd0);
    chk("rst.wb_out", wb_out, 64'd0);
    chk("rst.stall", {63'd0, stall}, 64'd0);
`ifdef MISALIGN_TRAP_EN
    chk("rst.trap_en", {63'd0, trap_en}, 64'd0);
    chk("rst.trap_cause", {60'd0, trap_cause}, 64'd0);
    chk("rst.trap_val", trap_val, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      set_op(0, 0, 0, 0, av[i].result, 64'h0, av[i].rd, av[i].pc);
      @(negedge clk);
      chk($sformatf("alu%0d.ma_rd", i), {59'd0, ma_rd}, {59'd0, av[i].rd});
      chk($sformatf("alu%0d.ma_out", i), ma_out, av[i].result);
      chk($sformatf("alu%0d.stall", i), {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("alu%0d.wb_rd", i), {59'd0, wb_rd}, {59'd0, av[i].rd});
      chk($sformatf("alu%0d.wb_out", i), wb_out, av[i].result);
      chk($sformatf("alu%0d.wb_pc", i), wb_pc, av[i].pc);
    end

    for (int i = 0; i < 11; i++) begin
      set_op(mv[i].ld, mv[i].st, mv[i].sz, mv[i].uns, mv[i].addr, mv[i].d2, mv[i].rd,
             64'h2000 + 64'(i * 16));
      mem_txn($sformatf("mv%0d", i), 0, 0, mv[i].rdata, 1'b0, mv[i].e_addr, mv[i].st,
              mv[i].e_wdata, mv[i].e_wmask, mv[i].e_rd, mv[i].e_out, 64'h2000 + 64'(i * 16));
    end

`ifdef MISALIGN_TRAP_EN
    set_op(1, 0, 2, 0, 64'h3002, 64'h0, 5'd4, 64'h3000);
    @(negedge clk);
    chk("trapld.en", {63'd0, trap_en}, 64'd1);
    chk("trapld.cause", {60'd0, trap_cause}, 64'd4);
    chk("trapld.val", trap_val, 64'h3002);
    chk("trapld.stall", {63'd0, stall}, 64'd0);
    chk("trapld.ma_rd", {59'd0, ma_rd}, 64'd0);
    @(posedge clk); #1;
    chk("trapld.wb_rd", {59'd0, wb_rd}, 64'd0);
    chk("trapld.req_valid", {63'd0, req_valid}, 64'd0);
    set_op(0, 1, 1, 0, 64'h2001, 64'h1234, 5'd8, 64'h3004);
    @(negedge clk);
    chk("trapst.en", {63'd0, trap_en}, 64'd1);
    chk("trapst.cause", {60'd0, trap_cause}, 64'd6);
    chk("trapst.val", trap_val, 64'h2001);
    @(posedge clk); #1;
    chk("trapst.req_valid", {63'd0, req_valid}, 64'd0);
    set_op(0, 0, 0, 0, 64'h0, 64'h0, 5'd1, 64'h3008);
    @(negedge clk);
    chk("trap.clear", {63'd0, trap_en}, 64'd0);
    @(posedge clk); #1;
`else
    set_op(1, 0, 2, 0, 64'h3002, 64'h0, 5'd4, 64'h3000);
    mem_txn("misal", 0, 0, 64'h1111_2222_8765_4321, 1'b0, 64'h3000, 1'b0, 64'h0, 8'h00,
            5'd4, 64'hFFFF_FFFF_8765_4321, 64'h3000);
`endif

    set_op(1, 0, 3, 0, 64'h9000, 64'h0, 5'd20, 64'h4000);
    mem_txn("bp", 5, 3, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h9000, 1'b0, 64'h0, 8'h00,
            5'd20, 64'h0123_4567_89AB_CDEF, 64'h4000);

    // Reset while waiting for the response
    set_op(1, 0, 0, 0, 64'hA001, 64'h0, 5'd6, 64'h5000);
    req_ready = 1'b1;
    @(negedge clk);
    chk("rstw.idle_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw.req_valid", {63'd0, req_valid}, 64'd1);
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(negedge clk);
    chk("rstw.wait_stall", {63'd0, stall}, 64'd1);
    rst_n = 1'b0;
    set_op(0, 0, 0, 0, 64'h0, 64'h0, 5'd0, 64'h0);
    #1;
    chk("rstw.stall", {63'd0, stall}, 64'd0);
    chk("rstw.req_valid", {63'd0, req_valid}, 64'd0);
    chk("rstw.req_addr", req_addr, 64'd0);
    chk("rstw.req_write", {63'd0, req_write}, 64'd0);
    chk("rstw.req_wmask", {56'd0, req_wmask}, 64'd0);
    chk("rstw.req_wdata", req_wdata, 64'd0);
    chk("rstw.wb_pc", wb_pc, 64'd0);
    chk("rstw.wb_rd", {59'd0, wb_rd}, 64'd0);
    chk("rstw.wb_out", wb_out, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_op(1, 0, 0, 1, 64'hA001, 64'h0, 5'd6, 64'h5004);
    mem_txn("post_rst", 0, 0, 64'h0000_0000_0000_C300, 1'b1, 64'hA000, 1'b0, 64'h0, 8'h00,
            5'd6, 64'hC3, 64'h5004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
